// File: rtl/snn_delay_layer_tm.sv
// Time-multiplexed LIF layer with per-synapse axonal delays: one shared update datapath scans N neurons per step.
// Optional per-neuron refractory counters are enabled by defining SNN_REFRACTORY_EN.
module snn_delay_layer_tm #(
    parameter int M     = 16,
    parameter int N     = 8,
    parameter int MEM_W = 6,
    parameter int DLY_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic [M-1:0]               input_spikes,
    input  logic [N*M*2-1:0]           weights,
    input  logic [N*M*(DLY_W+1)-1:0]   delays,
    input  logic [MEM_W-1:0]           threshold,
    input  logic [MEM_W-1:0]           decay,
    input  logic [MEM_W-1:0]           refractory_period,
    output logic [N*MEM_W-1:0]         membrane_potential_out,
    output logic [N-1:0]               output_spikes,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int D  = 2 ** DLY_W;
    localparam int SW = $clog2(M + 1) + 1;
    localparam int WW = MEM_W + SW + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [SW-1:0] S_ONE = 1;
    localparam logic signed [WW-1:0] V_MAX = WW'((1 << MEM_W) - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                ovr_q, ovr_d;
    logic [N-1:0]        shadow_q, shadow_d;
    logic [N-1:0]        out_q;
    logic                accept;
    logic [D-1:0]        hist_q [M];
    logic [MEM_W-1:0]    mem_q  [N];

    logic signed [SW-1:0] sum;
    logic signed [WW-1:0] v_ext, dec_ext, sum_ext, v1, v2w;
    logic [MEM_W-1:0]     v2, v_new;
    logic                 fire, spk;

`ifdef SNN_REFRACTORY_EN
    logic [MEM_W-1:0]     refr_q [N];
    logic [MEM_W-1:0]     r_new;
`else
    logic                 unused_refr;
    assign unused_refr = ^refractory_period;
`endif

    function automatic logic [MEM_W-1:0] sat_mem(input logic signed [WW-1:0] x);
        if (x < 0)
            return '0;
        else if (x > V_MAX)
            return V_MAX[MEM_W-1:0];
        else
            return x[MEM_W-1:0];
    endfunction

    // Synaptic sum for the neuron under the scan index, using delayed history taps
    always_comb begin
        sum = '0;
        for (int m = 0; m < M; m++) begin
            int               s;
            logic [1:0]       w;
            logic [DLY_W:0]   dl;
            logic             sp;
            s  = int'(idx_q) * M + m;
            w  = weights[s*2 +: 2];
            dl = delays[s*(DLY_W+1) +: DLY_W+1];
            sp = dl[DLY_W] ? hist_q[m][dl[DLY_W-1:0]] : hist_q[m][0];
            if (w[1] && sp)
                sum = w[0] ? (sum - S_ONE) : (sum + S_ONE);
        end
    end

    always_comb begin
        v_ext   = signed'(WW'(mem_q[idx_q]));
        dec_ext = signed'(WW'(decay));
        sum_ext = WW'(sum);
        v1      = v_ext - dec_ext;
        if (v1 < 0)
            v1 = '0;
        v2w  = v1 + sum_ext;
        v2   = sat_mem(v2w);
        fire = (v2 >= threshold);
    end

    always_comb begin
        v_new = v2;
        spk   = 1'b0;
`ifdef SNN_REFRACTORY_EN
        r_new = refr_q[idx_q];
        if (refr_q[idx_q] != '0) begin
            r_new = refr_q[idx_q] - 1'b1;
            v_new = '0;
        end else if (fire) begin
            spk   = 1'b1;
            v_new = '0;
            r_new = refractory_period;
        end
`else
        if (fire) begin
            spk   = 1'b1;
            v_new = '0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ovr_d    = ovr_q;
        accept   = 1'b0;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (step) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                shadow_d[idx_q] = spk;
                if (step)
                    ovr_d = 1'b1;
                if (idx_q == IW'(N - 1))
                    state_d = DONE;
                else
                    idx_d = idx_q + 1'b1;
            end
            DONE: begin
                // Back-to-back steps skip IDLE to sustain one step per N+1 cycles
                if (step) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ovr_q    <= 1'b0;
            shadow_q <= '0;
            out_q    <= '0;
            for (int m = 0; m < M; m++)
                hist_q[m] <= '0;
            for (int n = 0; n < N; n++) begin
                mem_q[n] <= '0;
`ifdef SNN_REFRACTORY_EN
                refr_q[n] <= '0;
`endif
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ovr_q    <= ovr_d;
            shadow_q <= shadow_d;
            if (accept) begin
                for (int m = 0; m < M; m++)
                    hist_q[m] <= {hist_q[m][D-2:0], input_spikes[m]};
            end
            if (state_q == SCAN) begin
                mem_q[idx_q] <= v_new;
`ifdef SNN_REFRACTORY_EN
                refr_q[idx_q] <= r_new;
`endif
            end
            // Spike vector is published only when the last neuron has been written
            if (state_q == SCAN && state_d == DONE)
                out_q <= shadow_d;
        end
    end

    always_comb begin
        membrane_potential_out = '0;
        for (int n = 0; n < N; n++)
            membrane_potential_out[n*MEM_W +: MEM_W] = mem_q[n];
    end

    assign output_spikes = out_q;
    assign busy          = (state_q == SCAN);
    assign done          = (state_q == DONE);
    assign overrun       = ovr_q;

endmodule
